// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle for the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid0;
    logic              rvalid1;
    logic [15:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_load;
    logic              mem_read;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
               mem_addr, mem_wdata, mem_load, mem_read, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
               mem_addr, mem_wdata, mem_load, mem_read, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester, single-port memory arbiter. One access every two cycles:
// an IDLE cycle picks a winner and latches its request, the following SERVE
// cycle drives the memory. Ties go to the port that was not granted last.
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          clear_n,
    mem_arbiter_if.slave  bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    logic [0:0]        r_state;
    logic              r_last_gnt;
    logic              r_sel;
    logic              r_we;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_busy;
    logic              r_mem_load;
    logic              r_mem_read;
    logic [15:0]       r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_rvalid0;
    logic              r_rvalid1;

    logic              w_any_req;
    logic              w_win;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

    // Pick the winning port and mux its request fields.
    always_comb begin
        w_any_req = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            w_win = ~r_last_gnt;
        end else if (bus.req1) begin
            w_win = 1'b1;
        end else begin
            w_win = 1'b0;
        end
        if (w_win) begin
            w_win_we    = bus.we1;
            w_win_addr  = bus.addr1;
            w_win_wdata = bus.wdata1;
        end else begin
            w_win_we    = bus.we0;
            w_win_addr  = bus.addr0;
            w_win_wdata = bus.wdata0;
        end
    end

    // IDLE/SERVE sequencer; the memory-side registers double as the latched
    // request so inputs moving during SERVE cannot disturb the access.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= ST_IDLE;
            r_last_gnt  <= 1'b1;
            r_sel       <= 1'b0;
            r_we        <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_load  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= {DATA_W{1'b0}};
            r_rdata0    <= {DATA_W{1'b0}};
            r_rdata1    <= {DATA_W{1'b0}};
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rvalid0 <= 1'b0;
                    r_rvalid1 <= 1'b0;
                    if (w_any_req) begin
                        r_state     <= ST_SERVE;
                        r_sel       <= w_win;
                        r_last_gnt  <= w_win;
                        r_we        <= w_win_we;
                        r_gnt0      <= ~w_win;
                        r_gnt1      <= w_win;
                        r_busy      <= 1'b1;
                        r_mem_load  <= w_win_we;
                        r_mem_read  <= ~w_win_we;
                        r_mem_addr  <= 16'(w_win_addr);
                        r_mem_wdata <= w_win_wdata;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERVE: begin
                    r_state     <= ST_IDLE;
                    r_gnt0      <= 1'b0;
                    r_gnt1      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_mem_load  <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_mem_addr  <= 16'h0000;
                    r_mem_wdata <= {DATA_W{1'b0}};
                    r_we        <= 1'b0;
                    if (!r_we) begin
                        if (r_sel) begin
                            r_rdata1  <= bus.mem_rdata;
                            r_rvalid1 <= 1'b1;
                        end else begin
                            r_rdata0  <= bus.mem_rdata;
                            r_rvalid0 <= 1'b1;
                        end
                    end else begin
                        r_rvalid0 <= 1'b0;
                        r_rvalid1 <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.busy      = r_busy;
    assign bus.mem_load  = r_mem_load;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written reset/tie
// sequences, then random two-requester traffic against a transaction model.
module tb_mem_arbiter;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic clear_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    function automatic logic [15:0] init_val(int i);
        if (i == 0) return 16'd9;
        else if (i == 5) return 16'd4;
        else return 16'(i) * 16'h0111;
    endfunction

    // Physical memory driven by the DUT's memory port.
    logic [15:0] mem [64];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
        end else if (bus.mem_load) begin
            mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[5:0]] : 16'hDEAD;

    // Transaction-level reference: a transaction granted after a free cycle
    // occupies the next cycle; on completion a read returns the model memory
    // word, a write updates it.
    logic [15:0] ref_mem [64];
    bit          m_init = 1'b0;
    logic        m_tx_valid, m_tx_port, m_tx_we, m_last;
    logic [5:0]  m_tx_addr;
    logic [15:0] m_tx_wdata;
    logic [15:0] m_rdata [2];
    logic        m_rvalid [2];

    function automatic logic pick(logic r0, logic r1, logic last);
        if (r0 && r1) return ~last;
        return r1;
    endfunction

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_tx_valid <= 1'b0;
            m_tx_port  <= 1'b0;
            m_tx_we    <= 1'b0;
            m_tx_addr  <= 6'd0;
            m_tx_wdata <= 16'h0000;
            m_last     <= 1'b1;
            m_rdata[0] <= 16'h0000;
            m_rdata[1] <= 16'h0000;
            m_rvalid[0] <= 1'b0;
            m_rvalid[1] <= 1'b0;
            if (!m_init) begin
                for (int i = 0; i < 64; i++) ref_mem[i] <= init_val(i);
                m_init <= 1'b1;
            end
        end else begin
            m_rvalid[0] <= 1'b0;
            m_rvalid[1] <= 1'b0;
            if (m_tx_valid) begin
                m_tx_valid <= 1'b0;
                if (m_tx_we) begin
                    ref_mem[m_tx_addr] <= m_tx_wdata;
                end else begin
                    m_rdata[m_tx_port]  <= ref_mem[m_tx_addr];
                    m_rvalid[m_tx_port] <= 1'b1;
                end
            end else if (bus.req0 || bus.req1) begin
                m_tx_valid <= 1'b1;
                m_tx_port  <= pick(bus.req0, bus.req1, m_last);
                m_last     <= pick(bus.req0, bus.req1, m_last);
                m_tx_we    <= pick(bus.req0, bus.req1, m_last) ? bus.we1 : bus.we0;
                m_tx_addr  <= pick(bus.req0, bus.req1, m_last) ? bus.addr1 : bus.addr0;
                m_tx_wdata <= pick(bus.req0, bus.req1, m_last) ? bus.wdata1 : bus.wdata0;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic get_gnt(int p);
        return (p == 0) ? bus.gnt0 : bus.gnt1;
    endfunction

    function automatic logic get_rvalid(int p);
        return (p == 0) ? bus.rvalid0 : bus.rvalid1;
    endfunction

    task automatic drive(int p, logic r, logic w, logic [5:0] a, logic [15:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic check_all();
        chk("gnt0", 32'(bus.gnt0), 32'(m_tx_valid && (m_tx_port == 1'b0)));
        chk("gnt1", 32'(bus.gnt1), 32'(m_tx_valid && (m_tx_port == 1'b1)));
        chk("busy", 32'(bus.busy), 32'(m_tx_valid));
        chk("mem_load", 32'(bus.mem_load), 32'(m_tx_valid && m_tx_we));
        chk("mem_read", 32'(bus.mem_read), 32'(m_tx_valid && !m_tx_we));
        chk("mem_addr", 32'(bus.mem_addr), m_tx_valid ? 32'(m_tx_addr) : 32'd0);
        chk("mem_wdata", 32'(bus.mem_wdata), m_tx_valid ? 32'(m_tx_wdata) : 32'd0);
        chk("rvalid0", 32'(bus.rvalid0), 32'(m_rvalid[0]));
        chk("rvalid1", 32'(bus.rvalid1), 32'(m_rvalid[1]));
        chk("rdata0", 32'(bus.rdata0), 32'(m_rdata[0]));
        chk("rdata1", 32'(bus.rdata1), 32'(m_rdata[1]));
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [5:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t        tv [7];
    logic [15:0] rd_hist [2];
    bit          pend [2];

    initial begin
        tv[0] = '{0, 1'b0, 6'd0,  16'h0000, 16'd9};
        tv[1] = '{1, 1'b1, 6'd3,  16'h00AB, 16'h0000};
        tv[2] = '{0, 1'b0, 6'd3,  16'h0000, 16'h00AB};
        tv[3] = '{1, 1'b0, 6'd5,  16'h5555, 16'd4};
        tv[4] = '{0, 1'b1, 6'd63, 16'hFFFF, 16'h0000};
        tv[5] = '{1, 1'b0, 6'd63, 16'h0000, 16'hFFFF};
        tv[6] = '{0, 1'b0, 6'd1,  16'h1111, 16'h0111};
        rd_hist[0] = 16'h0000;
        rd_hist[1] = 16'h0000;

        clear_n = 1'b0;
        drive(0, 1'b0, 1'b0, 6'd0, 16'h0000);
        drive(1, 1'b0, 1'b0, 6'd0, 16'h0000);
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_load", 32'(bus.mem_load), 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_rdata0", 32'(bus.rdata0), 32'd0);
        chk("rst_rdata1", 32'(bus.rdata1), 32'd0);
        chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        clear_n = 1'b1;

        // Directed single accesses from the table.
        for (int k = 0; k < 7; k++) begin
            drive(tv[k].port, 1'b1, tv[k].we, tv[k].addr, tv[k].wdata);
            @(negedge clk);
            chk("tv_gnt", 32'(get_gnt(tv[k].port)), 32'd1);
            chk("tv_gnt_other", 32'(get_gnt(1 - tv[k].port)), 32'd0);
            chk("tv_mem_load", 32'(bus.mem_load), 32'(tv[k].we));
            chk("tv_mem_read", 32'(bus.mem_read), 32'(!tv[k].we));
            chk("tv_mem_addr", 32'(bus.mem_addr), 32'(tv[k].addr));
            chk("tv_mem_wdata", 32'(bus.mem_wdata), 32'(tv[k].wdata));
            drive(tv[k].port, 1'b0, ~tv[k].we, ~tv[k].addr, ~tv[k].wdata);
            #1;
            chk("tv_hold_addr", 32'(bus.mem_addr), 32'(tv[k].addr));
            chk("tv_hold_wdata", 32'(bus.mem_wdata), 32'(tv[k].wdata));
            chk("tv_hold_load", 32'(bus.mem_load), 32'(tv[k].we));
            @(negedge clk);
            if (!tv[k].we) rd_hist[tv[k].port] = tv[k].exp_rd;
            chk("tv_rvalid", 32'(get_rvalid(tv[k].port)), 32'(!tv[k].we));
            chk("tv_rvalid_other", 32'(get_rvalid(1 - tv[k].port)), 32'd0);
            chk("tv_rdata0", 32'(bus.rdata0), 32'(rd_hist[0]));
            chk("tv_rdata1", 32'(bus.rdata1), 32'(rd_hist[1]));
            chk("tv_idle_busy", 32'(bus.busy), 32'd0);
        end

        // Both requesting from reset release: grants alternate 0,1,0,1.
        clear_n = 1'b0;
        drive(0, 1'b1, 1'b0, 6'd1, 16'h0000);
        drive(1, 1'b1, 1'b0, 6'd2, 16'h0000);
        @(negedge clk);
        clear_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("alt_gnt0", 32'(bus.gnt0), 32'((k % 4) == 1));
            chk("alt_gnt1", 32'(bus.gnt1), 32'((k % 4) == 3));
        end

        // Reset in the middle of a write: aborted, memory untouched.
        drive(0, 1'b0, 1'b0, 6'd0, 16'h0000);
        drive(1, 1'b0, 1'b0, 6'd0, 16'h0000);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 6'd5, 16'h1234);
        @(negedge clk);
        chk("abort_gnt1", 32'(bus.gnt1), 32'd1);
        chk("abort_load_before", 32'(bus.mem_load), 32'd1);
        #1;
        clear_n = 1'b0;
        #1;
        chk("abort_load", 32'(bus.mem_load), 32'd0);
        chk("abort_gnt1_low", 32'(bus.gnt1), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("abort_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("abort_rdata0", 32'(bus.rdata0), 32'd0);
        chk("abort_rdata1", 32'(bus.rdata1), 32'd0);
        drive(1, 1'b0, 1'b0, 6'd0, 16'h0000);
        @(negedge clk);
        chk("abort_word5", 32'(mem[5]), 32'h0004);
        chk("abort_rvalid1", 32'(bus.rvalid1), 32'd0);
        drive(0, 1'b1, 1'b0, 6'd7, 16'h0000);
        drive(1, 1'b1, 1'b0, 6'd8, 16'h0000);
        clear_n = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt0", 32'(bus.gnt0), 32'd1);
        chk("post_rst_gnt1", 32'(bus.gnt1), 32'd0);
        pend[0] = 1'b1;
        pend[1] = 1'b1;

        // Random traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            check_all();
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] || get_gnt(p)) begin
                    if ($urandom_range(0, 3) != 0) begin
                        drive(p, 1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 16'($urandom));
                        pend[p] = 1'b1;
                    end else begin
                        drive(p, 1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 16'($urandom));
                        pend[p] = 1'b0;
                    end
                end
            end
        end

        // Drain and compare memory contents word by word.
        drive(0, 1'b0, 1'b0, 6'd0, 16'h0000);
        drive(1, 1'b0, 1'b0, 6'd0, 16'h0000);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            chk("mem_word", 32'(mem[i]), 32'(ref_mem[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word-address width of each requester port (64-word data memory).
REQ-002 SHALL have parameter DATA_W, default 16, data width of all data buses.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port clear_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0/req1  input  1  access request from requester 0/1.
REQ-006 SHALL have ports we0/we1  input  1  1 = write access, 0 = read access.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  word address.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_W  write data.
REQ-009 SHALL have ports gnt0/gnt1  output  1  registered grant, one-cycle pulse in the cycle the access is performed.
REQ-010 SHALL have ports rdata0/rdata1  output  DATA_W  registered read data.
REQ-011 SHALL have ports rvalid0/rvalid1  output  1  one-cycle pulse; rdataN valid.
REQ-012 SHALL have port mem_addr  output  16  memory address; addr zero-extended to 16 bits.
REQ-013 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-014 SHALL have port mem_load  output  1  memory write enable; memory commits on the rising edge ending the cycle.
REQ-015 SHALL have port mem_read  output  1  memory read enable; memory drives mem_rdata combinationally while high.
REQ-016 SHALL have port mem_rdata  input  DATA_W  memory read data; undefined/Z while mem_read = 0.
REQ-017 SHALL have port busy  output  1  high in SERVE state.

Function
REQ-018 SHALL implement FSM with states IDLE and SERVE; one access per two cycles.
REQ-019 In IDLE with no req: SHALL remain in IDLE.
REQ-020 In IDLE with at least one req: SHALL select a winner, latch its we/addr/wdata and port id into internal registers, and enter SERVE next edge.
REQ-021 Arbitration: a single requester wins; both requesting -> port not equal to last_gnt wins; last_gnt updated to the winner on the same edge.
REQ-022 In SERVE: gntW = 1, busy = 1, mem_addr/mem_wdata from latched values; mem_load = latched we; mem_read = NOT latched we.
REQ-023 SERVE SHALL always return to IDLE on the next edge (no back-to-back SERVE).
REQ-024 Read in SERVE: mem_rdata captured into rdataW at the edge ending SERVE; rvalidW = 1 for exactly the following cycle; rdata of the other port unchanged.
REQ-025 Write in SERVE: no rvalid pulse; rdata registers unchanged.
REQ-026 Outside SERVE: mem_load = 0, mem_read = 0, mem_addr = 0, mem_wdata = 0, gnt0 = gnt1 = 0.
REQ-027 Requester SHALL hold req/we/addr/wdata stable until gnt; it may deassert req on the edge ending the gnt cycle; a req still high in the IDLE cycle after gnt is a new request.
REQ-028 Read latency from req assertion (IDLE, no contention) = rvalid 2 cycles later; loser of a tie is served in the next IDLE→SERVE pair (waits 2 cycles).
REQ-029 Inputs changing during SERVE SHALL NOT affect the access in progress.

Reset
REQ-030 clear_n low SHALL immediately force state IDLE, last_gnt = 1 (port 0 wins first tie), all gnt/rvalid/mem_load/mem_read/busy = 0, rdata0/rdata1 = 0, latched request registers = 0.
REQ-031 Reset asserted during SERVE SHALL abort the access: mem_load drops asynchronously, so no write commits; no rvalid follows.
REQ-032 After clear_n deasserts, first arbitration SHALL occur on the first rising edge with clear_n high.

Verification
REQ-033 Memory word 0 = 9; req0 read addr0 = 0 for one IDLE cycle -> gnt0 next cycle with mem_read = 1, mem_addr = 0; rvalid0 = 1, rdata0 = 9 the cycle after.
REQ-034 req1 write addr1 = 3, wdata1 = 16'h00AB -> gnt1 with mem_load = 1; subsequent req0 read addr 3 -> rdata0 = 16'h00AB, rvalid1 never pulses.
REQ-035 req0 and req1 both held high from reset release -> grants alternate gnt0, gnt1, gnt0, gnt1, each separated by one IDLE cycle.
REQ-036 clear_n pulsed low mid-SERVE of write addr 5 wdata 16'h1234 -> mem_load falls with clear_n, word 5 keeps old value 4, all outputs 0, next tie granted to port 0.
REQ-037 Change addr0/wdata0 during gnt0 cycle -> mem_addr/mem_wdata keep the latched values for that cycle.
